// File: rtl/reg_checkpoint_tracker.sv
// Branch checkpoint tracker: records the physical r/s registers checked out under each
// unresolved branch and pulses restore with those masks on a mispredict. Optional macro: CKPT_ERR_CHECK_EN.
module reg_checkpoint_tracker #(
  parameter int NUM_D_REG = 16,
  parameter int NUM_S_REG = 8,
  parameter int NUM_CKPT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_r_valid,
  input  logic [$clog2(NUM_D_REG)-1:0] alloc_r_addr,
  input  logic                         alloc_s_valid,
  input  logic [$clog2(NUM_S_REG)-1:0] alloc_s_addr,
  input  logic                         branch_valid,
  output logic [$clog2(NUM_CKPT)-1:0]  branch_tag,
  input  logic                         resolve_valid,
  input  logic                         resolve_correct,
  output logic                         full,
  output logic                         empty,
  output logic                         restore,
`ifdef CKPT_ERR_CHECK_EN
  output logic                         err,
`endif
  output logic [NUM_D_REG-1:0]         r_free_list,
  output logic [NUM_S_REG-1:0]         s_free_list
);

  localparam int PW = $clog2(NUM_CKPT);
  localparam int CW = PW + 1;

  logic [PW-1:0]        head_reg;
  logic [PW-1:0]        tail_reg;
  logic [CW-1:0]        count_reg;
  logic [NUM_D_REG-1:0] r_mask_all [NUM_CKPT];
  logic [NUM_S_REG-1:0] s_mask_all [NUM_CKPT];
  logic [NUM_D_REG-1:0] r_bit;
  logic [NUM_S_REG-1:0] s_bit;
  logic                 resolve_ok;
  logic                 correct;
  logic                 mispredict;
  logic                 accept_branch;

  assign full       = (count_reg == CW'(NUM_CKPT));
  assign empty      = (count_reg == '0);
  assign branch_tag = tail_reg;

  // Checkout is suppressed by reg_tracker while restore is high, so nothing is recorded then.
  always_comb begin
    r_bit = '0;
    s_bit = '0;
    if (alloc_r_valid && !restore) r_bit[alloc_r_addr] = 1'b1;
    if (alloc_s_valid && !restore) s_bit[alloc_s_addr] = 1'b1;
  end

  assign resolve_ok    = resolve_valid && !empty;
  assign correct       = resolve_ok && resolve_correct;
  assign mispredict    = resolve_ok && !resolve_correct;
  // A retiring head frees a slot in the same cycle, so a full tracker still accepts the pair.
  assign accept_branch = branch_valid && !restore && !mispredict && (!full || correct);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
      logic [NUM_D_REG-1:0] r_mask_reg;
      logic [NUM_S_REG-1:0] s_mask_reg;
      logic [PW-1:0]        offset;
      logic                 live;
      logic                 is_new;
      logic                 is_retired;

      assign offset     = PW'(gi) - head_reg;
      assign live       = ({1'b0, offset} < count_reg);
      assign is_new     = accept_branch && (tail_reg == PW'(gi));
      assign is_retired = correct && (head_reg == PW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_mask_reg <= '0;
          s_mask_reg <= '0;
        end else if (mispredict || is_new || is_retired) begin
          r_mask_reg <= '0;
          s_mask_reg <= '0;
        end else if (live) begin
          r_mask_reg <= r_mask_reg | r_bit;
          s_mask_reg <= s_mask_reg | s_bit;
        end
      end

      assign r_mask_all[gi] = r_mask_reg;
      assign s_mask_all[gi] = s_mask_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      restore     <= 1'b0;
      r_free_list <= '0;
      s_free_list <= '0;
    end else begin
      restore     <= mispredict;
      r_free_list <= mispredict ? (r_mask_all[head_reg] | r_bit) : '0;
      s_free_list <= mispredict ? (s_mask_all[head_reg] | s_bit) : '0;
      if (mispredict) begin
        head_reg  <= tail_reg;
        count_reg <= '0;
      end else begin
        if (correct)       head_reg <= head_reg + PW'(1);
        if (accept_branch) tail_reg <= tail_reg + PW'(1);
        if (accept_branch && !correct)      count_reg <= count_reg + CW'(1);
        else if (correct && !accept_branch) count_reg <= count_reg - CW'(1);
      end
    end
  end

`ifdef CKPT_ERR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((branch_valid && full && !correct) || (resolve_valid && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_checkpoint_tracker.sv
// Bench for reg_checkpoint_tracker: directed vector table, async-reset corner case,
// then random traffic against a queue-based reference model.
module tb_reg_checkpoint_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_r_valid = 1'b0;
  logic [3:0]  alloc_r_addr = '0;
  logic        alloc_s_valid = 1'b0;
  logic [2:0]  alloc_s_addr = '0;
  logic        branch_valid = 1'b0;
  logic [1:0]  branch_tag;
  logic        resolve_valid = 1'b0;
  logic        resolve_correct = 1'b0;
  logic        full;
  logic        empty;
  logic        restore;
  logic [15:0] r_free_list;
  logic [7:0]  s_free_list;
`ifdef CKPT_ERR_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int failures = 0;

  reg_checkpoint_tracker #(.NUM_D_REG(16), .NUM_S_REG(8), .NUM_CKPT(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_r_valid(alloc_r_valid), .alloc_r_addr(alloc_r_addr),
    .alloc_s_valid(alloc_s_valid), .alloc_s_addr(alloc_s_addr),
    .branch_valid(branch_valid), .branch_tag(branch_tag),
    .resolve_valid(resolve_valid), .resolve_correct(resolve_correct),
    .full(full), .empty(empty), .restore(restore),
`ifdef CKPT_ERR_CHECK_EN
    .err(err),
`endif
    .r_free_list(r_free_list), .s_free_list(s_free_list)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        bv;
    logic        rv;
    logic        rc;
    logic        arv;
    logic [3:0]  ar;
    logic        asv;
    logic [2:0]  as_;
    logic        e_restore;
    logic [15:0] e_r;
    logic [7:0]  e_s;
    logic        e_empty;
    logic        e_full;
    logic [1:0]  e_tag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic bv, input logic rv, input logic rc,
                     input logic arv, input logic [3:0] ar, input logic asv, input logic [2:0] as_,
                     input logic er, input logic [15:0] erf, input logic [7:0] esf,
                     input logic ee, input logic ef, input logic [1:0] et);
    vec_t v;
    v.rst = r; v.bv = bv; v.rv = rv; v.rc = rc; v.arv = arv; v.ar = ar; v.asv = asv; v.as_ = as_;
    v.e_restore = er; v.e_r = erf; v.e_s = esf; v.e_empty = ee; v.e_full = ef; v.e_tag = et;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic bv, input logic rv, input logic rc,
                       input logic arv, input logic [3:0] ar, input logic asv, input logic [2:0] as_);
    branch_valid = bv; resolve_valid = rv; resolve_correct = rc;
    alloc_r_valid = arv; alloc_r_addr = ar; alloc_s_valid = asv; alloc_s_addr = as_;
  endtask

  // Reference model: the live checkpoints as a queue of masks, oldest first.
  logic [15:0] q_r[$];
  logic [7:0]  q_s[$];
  int          m_tail;
  logic        m_restore;
  logic [15:0] m_rf;
  logic [7:0]  m_sf;

  task automatic model_reset();
    q_r.delete(); q_s.delete();
    m_tail = 0; m_restore = 1'b0; m_rf = '0; m_sf = '0;
  endtask

  task automatic model_step();
    logic [15:0] rb;
    logic [7:0]  sb;
    logic        n_res;
    logic [15:0] n_rf;
    logic [7:0]  n_sf;
    rb = '0; sb = '0;
    if (alloc_r_valid && !m_restore) rb[alloc_r_addr] = 1'b1;
    if (alloc_s_valid && !m_restore) sb[alloc_s_addr] = 1'b1;
    n_res = 1'b0; n_rf = '0; n_sf = '0;
    if (resolve_valid && q_r.size() > 0) begin
      if (!resolve_correct) begin
        n_res = 1'b1;
        n_rf = q_r[0] | rb;
        n_sf = q_s[0] | sb;
        q_r.delete(); q_s.delete();
      end else begin
        void'(q_r.pop_front());
        void'(q_s.pop_front());
        foreach (q_r[i]) q_r[i] = q_r[i] | rb;
        foreach (q_s[i]) q_s[i] = q_s[i] | sb;
        if (branch_valid && !m_restore) begin
          q_r.push_back('0); q_s.push_back('0);
          m_tail = (m_tail + 1) % 4;
        end
      end
    end else begin
      foreach (q_r[i]) q_r[i] = q_r[i] | rb;
      foreach (q_s[i]) q_s[i] = q_s[i] | sb;
      if (branch_valid && !m_restore && q_r.size() < 4) begin
        q_r.push_back('0); q_s.push_back('0);
        m_tail = (m_tail + 1) % 4;
      end
    end
    m_restore = n_res; m_rf = n_rf; m_sf = n_sf;
  endtask

  initial begin
    // rst bv rv rc arv ar asv as | restore r_free s_free empty full tag
    add(1, 0,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd0); // reset
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd1); // branch tag 0
    add(0, 0,0,0, 1,4'd3,1,3'd1, 0,16'h0000,8'h00, 0,0,2'd1); // alloc r3 s1
    add(0, 0,1,0, 0,4'd0,0,3'd0, 1,16'h0008,8'h02, 1,0,2'd1); // mispredict
    add(0, 0,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd1); // pulse ends
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd2); // branch A
    add(0, 0,0,0, 1,4'd5,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd2); // alloc r5
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd3); // branch B
    add(0, 0,0,0, 1,4'd6,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd3); // alloc r6
    add(0, 0,1,1, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd3); // resolve A ok
    add(0, 0,1,0, 0,4'd0,0,3'd0, 1,16'h0040,8'h00, 1,0,2'd3); // mispredict B
    add(0, 0,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd3);
    add(1, 0,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd0); // reset
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd1);
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd2);
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd3);
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,1,2'd0); // full, tag wraps
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,1,2'd0); // dropped
    add(0, 1,1,1, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,1,2'd1); // branch+resolve at full
    add(0, 1,1,0, 1,4'd9,0,3'd0, 1,16'h0200,8'h00, 1,0,2'd1); // mispredict+alloc r9+branch
    add(0, 0,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd1);
    add(0, 0,1,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd1); // resolve while empty
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd2);
    add(0, 0,1,0, 1,4'd2,1,3'd5, 1,16'h0004,8'h20, 1,0,2'd2);
    add(0, 1,0,0, 1,4'd4,0,3'd0, 0,16'h0000,8'h00, 1,0,2'd2); // restore cycle: ignored
    add(0, 1,0,0, 0,4'd0,0,3'd0, 0,16'h0000,8'h00, 0,0,2'd3);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      drive(vecs[i].bv, vecs[i].rv, vecs[i].rc, vecs[i].arv, vecs[i].ar, vecs[i].asv, vecs[i].as_);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_restore", i), 32'(restore), 32'(vecs[i].e_restore));
      check($sformatf("v%0d_r_free", i), 32'(r_free_list), 32'(vecs[i].e_r));
      check($sformatf("v%0d_s_free", i), 32'(s_free_list), 32'(vecs[i].e_s));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_tag", i), 32'(branch_tag), 32'(vecs[i].e_tag));
      $display("vec %0d rst=%0b bv=%0b rv=%0b rc=%0b -> restore=%0b r=%04h s=%02h empty=%0b full=%0b tag=%0d",
               i, vecs[i].rst, vecs[i].bv, vecs[i].rv, vecs[i].rc, restore, r_free_list, s_free_list,
               empty, full, branch_tag);
`ifdef CKPT_ERR_CHECK_EN
      if (i == 17) check("err_overflow", 32'(err), 32'd1);
`endif
    end

    // Async reset lands between the mispredict input and its restore edge.
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 1, 4'd7, 0, 3'd0);
    @(negedge clk);
    drive(0, 1, 0, 0, 4'd0, 0, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_empty", 32'(empty), 32'd1);
    check("async_tag", 32'(branch_tag), 32'd0);
    @(posedge clk);
    #1;
    check("async_restore", 32'(restore), 32'd0);
    check("async_r_free", 32'(r_free_list), 32'd0);
    $display("async reset: restore=%0b empty=%0b tag=%0d", restore, empty, branch_tag);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 0, 3'd0);

    // Random traffic against the model.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(99) < 45, $urandom_range(99) < 30, $urandom_range(99) < 70,
            $urandom_range(99) < 60, 4'($urandom_range(15)),
            $urandom_range(99) < 50, 3'($urandom_range(7)));
      model_step();
      @(posedge clk);
      #1;
      check("rnd_restore", 32'(restore), 32'(m_restore));
      check("rnd_r_free", 32'(r_free_list), 32'(m_rf));
      check("rnd_s_free", 32'(s_free_list), 32'(m_sf));
      check("rnd_empty", 32'(empty), 32'(q_r.size() == 0));
      check("rnd_full", 32'(full), 32'(q_r.size() == 4));
      check("rnd_tag", 32'(branch_tag), 32'(m_tail));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
